// File: rtl/motor_speed_scheduler.sv
// motor_speed_scheduler
//
// Measures encoder pulse periods on NUM_CH motor channels and time-shares one
// external combinational period-to-speed converter between them with
// round-robin arbitration. The latest 8-bit speed of every channel is held for
// the motor control loop; a channel whose period counter saturates is treated
// as stalled and reports speed 0.
//
// Build option:
//   MOTOR_SPEED_AVG_EN  when defined, a non-stall update writes the rounded
//                       mean of the previous speed and the new converter result
//                       instead of the converter result alone.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   enc_in       raw encoder pulse per channel (asynchronous to clk)
//   conv_period  registered period presented to the shared converter
//   conv_speed   converter result for conv_period
//   speed_flat   speed of channel i on bits [8i+7:8i]
//   speed_valid  one-cycle pulse when the speed of channel i is updated
//   busy         high while a conversion is in progress
module motor_speed_scheduler #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 16,
   parameter int PRESCALE_DIV = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     enc_in,
   output logic [CNT_W-1:0]      conv_period,
   input  logic [7:0]            conv_speed,
   output logic [NUM_CH*8-1:0]   speed_flat,
   output logic [NUM_CH-1:0]     speed_valid,
   output logic                  busy
);

   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE_DIV - 1);
   localparam logic [GW-1:0]    LAST_CH  = GW'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CAPT
   } state_t;

`ifdef MOTOR_SPEED_AVG_EN
   // Rounded mean of previous and new speed; the 9-bit sum cannot overflow.
   function automatic logic [7:0] avg_speed(input logic [7:0] prev,
                                            input logic [7:0] conv);
      logic [8:0] sum;
      sum = {1'b0, prev} + {1'b0, conv} + 9'd1;
      return sum[8:1];
   endfunction
`endif

   logic [NUM_CH-1:0]              sync1_q, sync1_d;
   logic [NUM_CH-1:0]              sync2_q, sync2_d;
   logic [NUM_CH-1:0]              sync3_q, sync3_d;
   logic [PW-1:0]                  pre_q, pre_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   per_q, per_d;
   logic [NUM_CH-1:0]              pend_q, pend_d;
   logic [NUM_CH-1:0]              stall_q, stall_d;
   logic [NUM_CH-1:0]              stopped_q, stopped_d;
   state_t                         state_q, state_d;
   logic [GW-1:0]                  grant_q, grant_d;
   logic [GW-1:0]                  last_grant_q, last_grant_d;
   logic                           cur_stall_q, cur_stall_d;
   logic [CNT_W-1:0]               conv_period_q, conv_period_d;
   logic [NUM_CH-1:0][7:0]         speed_q, speed_d;
   logic [NUM_CH-1:0]              speed_valid_q, speed_valid_d;

   logic [NUM_CH-1:0]              edge_w;
   logic                           tick;
   logic                           rr_found;
   logic [GW-1:0]                  rr_idx;

   // Synchronizer chain and rising-edge detect; the third flop only serves
   // as the "previous" sample for the edge detector.
   always_comb begin
      sync1_d = enc_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      edge_w  = sync2_q & ~sync3_q;
   end

   // Prescaler: tick in the cycle the count sits at its last value.
   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + 1'b1;
   end

   // Round-robin search starting just after the last served channel.
   always_comb begin
      int cand;
      rr_found = 1'b0;
      rr_idx   = last_grant_q;
      cand     = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = (int'(last_grant_q) + k) % NUM_CH;
         if (!rr_found && pend_q[GW'(cand)]) begin
            rr_found = 1'b1;
            rr_idx   = GW'(cand);
         end
      end
   end

   always_comb begin
      cnt_d         = cnt_q;
      per_d         = per_q;
      pend_d        = pend_q;
      stall_d       = stall_q;
      stopped_d     = stopped_q;
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      cur_stall_d   = cur_stall_q;
      conv_period_d = conv_period_q;
      speed_d       = speed_q;
      speed_valid_d = '0;

      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               grant_d        = rr_idx;
               conv_period_d  = per_q[rr_idx];
               cur_stall_d    = stall_q[rr_idx];
               pend_d[rr_idx] = 1'b0;
               state_d        = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d = S_CAPT;
         end
         S_CAPT: begin
`ifdef MOTOR_SPEED_AVG_EN
            speed_d[grant_q] = cur_stall_q ? 8'd0
                                           : avg_speed(speed_q[grant_q], conv_speed);
`else
            speed_d[grant_q] = cur_stall_q ? 8'd0 : conv_speed;
`endif
            speed_valid_d[grant_q] = 1'b1;
            last_grant_d           = grant_q;
            state_d                = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Channel updates come after the grant clear so that a new capture on
      // the channel being granted re-arms its pending flag.
      for (int i = 0; i < NUM_CH; i++) begin
         if (edge_w[i]) begin
            cnt_d[i] = tick ? CNT_W'(1) : '0;
            if (stopped_q[i]) begin
               // First edge after reset or stall has no valid start point.
               stopped_d[i] = 1'b0;
            end else begin
               per_d[i]   = cnt_q[i];
               pend_d[i]  = 1'b1;
               stall_d[i] = 1'b0;
            end
         end else begin
            if (tick && (cnt_q[i] != CNT_MAX)) begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
            // Stall fires once; stopped stays set until the next edge.
            if ((cnt_q[i] == CNT_MAX) && !stopped_q[i]) begin
               stopped_d[i] = 1'b1;
               pend_d[i]    = 1'b1;
               stall_d[i]   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         sync3_q       <= '0;
         pre_q         <= '0;
         cnt_q         <= '0;
         per_q         <= '0;
         pend_q        <= '0;
         stall_q       <= '0;
         stopped_q     <= '1;
         state_q       <= S_IDLE;
         grant_q       <= '0;
         last_grant_q  <= LAST_CH;
         cur_stall_q   <= 1'b0;
         conv_period_q <= '0;
         speed_q       <= '0;
         speed_valid_q <= '0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         sync3_q       <= sync3_d;
         pre_q         <= pre_d;
         cnt_q         <= cnt_d;
         per_q         <= per_d;
         pend_q        <= pend_d;
         stall_q       <= stall_d;
         stopped_q     <= stopped_d;
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         cur_stall_q   <= cur_stall_d;
         conv_period_q <= conv_period_d;
         speed_q       <= speed_d;
         speed_valid_q <= speed_valid_d;
      end
   end

   assign conv_period = conv_period_q;
   assign speed_flat  = speed_q;
   assign speed_valid = speed_valid_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_motor_speed_scheduler.sv
// Testbench for motor_speed_scheduler (PRESCALE_DIV = 1, so one count per clk).
// The converter is modelled as speed = floor(8250 / period), clamped to 255.
module tb_motor_speed_scheduler;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_CH-1:0]     enc_in = '0;
   logic [CNT_W-1:0]      conv_period;
   logic [7:0]            conv_speed;
   logic [NUM_CH*8-1:0]   speed_flat;
   logic [NUM_CH-1:0]     speed_valid;
   logic                  busy;

   always #5 clk = ~clk;

   function automatic logic [7:0] conv_model(input logic [CNT_W-1:0] p);
      int v;
      if (p == '0) return 8'd255;
      v = 8250 / int'(p);
      if (v > 255) v = 255;
      return 8'(v);
   endfunction

   assign conv_speed = conv_model(conv_period);

   motor_speed_scheduler #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_DIV(1)
   ) dut (
      .clk(clk), .rst(rst), .enc_in(enc_in), .conv_period(conv_period),
      .conv_speed(conv_speed), .speed_flat(speed_flat),
      .speed_valid(speed_valid), .busy(busy)
   );

   typedef struct {
      int         ch;
      int         per;
      bit         chk_per;
      logic [7:0] spd;
      int         gap;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [7:0] model_spd [NUM_CH];
   int         ev [NUM_CH][3];

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Expected response for one conversion, in grant order.
   task automatic push(input int ch, input int per, input bit chk, input bit stl,
                       input int gap);
      exp_t       e;
      logic [7:0] c;
`ifdef MOTOR_SPEED_AVG_EN
      logic [8:0] s;
`endif
      c = stl ? 8'd0 : conv_model(16'(per));
`ifdef MOTOR_SPEED_AVG_EN
      if (!stl) begin
         s = {1'b0, model_spd[ch]} + {1'b0, c} + 9'd1;
         c = s[8:1];
      end
`endif
      model_spd[ch] = c;
      e.ch = ch; e.per = per; e.chk_per = chk; e.spd = c; e.gap = gap;
      sb.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: pops one expectation per speed_valid bit.
   initial begin
      exp_t e;
      int   last_vcyc;
      int   grant_cyc;
      bit   busy_prev;
      last_vcyc = 0; grant_cyc = 0; busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_prev = 1'b0;
         end else begin
            if (busy && !busy_prev) grant_cyc = cyc;
            busy_prev = busy;
            for (int i = 0; i < NUM_CH; i++) begin
               if (speed_valid[i]) begin
                  if (sb.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_valid: ch%0d speed %0d, required no update (cycle %0d)",
                              i, speed_flat[i*8 +: 8], cyc);
                  end else begin
                     e = sb.pop_front();
                     check("grant_ch", i, e.ch);
                     check("speed", speed_flat[i*8 +: 8], e.spd);
                     check("grant_to_valid", cyc - grant_cyc, 2);
                     if (e.chk_per) check("conv_period", conv_period, e.per);
                     if (e.gap > 0) check("valid_gap", cyc - last_vcyc, e.gap);
                  end
                  last_vcyc = cyc;
               end
            end
         end
      end
   end

   task automatic clear_ev();
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < 3; k++) ev[c][k] = -1;
   endtask

   // One-cycle pin pulses at the scheduled offsets; counts busy cycles.
   task automatic drive(input int len, output int bcnt);
      bcnt = 0;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         if (busy) bcnt++;
         for (int ch = 0; ch < NUM_CH; ch++)
            enc_in[ch] = (ev[ch][0] == c) || (ev[ch][1] == c) || (ev[ch][2] == c);
      end
      enc_in = '0;
   endtask

   task automatic drain(input int limit, input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: %0d updates outstanding after %0d cycles, required 0",
                  name, sb.size(), n);
         sb.delete();
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      if (chk) begin
         check("rst_speed_flat", speed_flat, 0);
         check("rst_speed_valid", speed_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_conv_period", conv_period, 0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < NUM_CH; c++) model_spd[c] = 8'd0;
   endtask

   initial begin
      int bc;
      int w;
      for (int c = 0; c < NUM_CH; c++) model_spd[c] = 8'd0;

      // ch0: discarded first edge, period 100, then period 50.
      do_reset(1'b1);
      clear_ev();
      ev[0][0] = 0; ev[0][1] = 100; ev[0][2] = 150;
      push(0, 100, 1'b1, 1'b0, 0);
      push(0, 50, 1'b1, 1'b0, 50);
      drive(170, bc);
      check("busy_cycles", bc, 4);
      drain(50, "t1_drain");

      // Simultaneous second edges on all channels.
      do_reset(1'b0);
      clear_ev();
      ev[2][0] = 0;    ev[2][1] = 4000;
      ev[0][0] = 3900; ev[0][1] = 4000;
      ev[3][0] = 3900; ev[3][1] = 4000;
      ev[1][0] = 3950; ev[1][1] = 4000;
      push(0, 100, 1'b1, 1'b0, 0);
      push(1, 50, 1'b1, 1'b0, 3);
      push(2, 4000, 1'b1, 1'b0, 3);
      push(3, 100, 1'b1, 1'b0, 3);
      drive(4020, bc);
      drain(50, "t2_drain");

      // ch1 captures twice while ch0 is converting; only the latest survives.
      do_reset(1'b0);
      clear_ev();
      ev[0][0] = 0; ev[0][1] = 100;
      ev[1][0] = 0; ev[1][1] = 101; ev[1][2] = 103;
      push(0, 100, 1'b1, 1'b0, 0);
      push(1, 2, 1'b1, 1'b0, 3);
      drive(120, bc);
      drain(50, "t3_drain");

      // ch2 stall, then discarded edge, then a normal update.
      do_reset(1'b0);
      clear_ev();
      ev[2][0] = 0; ev[2][1] = 100;
      push(2, 100, 1'b1, 1'b0, 0);
      drive(112, bc);
      drain(50, "t4_first");
      push(2, 0, 1'b0, 1'b1, 0);
      drain(70000, "t4_stall");
      clear_ev();
      ev[2][0] = 0; ev[2][1] = 50;
      push(2, 50, 1'b1, 1'b0, 0);
      drive(70, bc);
      drain(50, "t4_restart");

      // Reset while the ch1 conversion sits in WAIT.
      clear_ev();
      ev[1][0] = 0; ev[1][1] = 100;
      drive(102, bc);
      w = 0;
      while (!busy && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("busy_before_abort", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_speed_flat", speed_flat, 0);
      check("abort_conv_period", conv_period, 0);
      check("abort_busy", busy, 0);
      check("abort_speed_valid", speed_valid, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < NUM_CH; c++) model_spd[c] = 8'd0;
      repeat (10) @(negedge clk);
      clear_ev();
      ev[0][0] = 0; ev[0][1] = 100;
      ev[3][0] = 0; ev[3][1] = 100;
      push(0, 100, 1'b1, 1'b0, 0);
      push(3, 100, 1'b1, 1'b0, 3);
      drive(115, bc);
      drain(50, "t5_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
